// File: rtl/a23_cache_flush_seq.sv
// Cache flush sequencer: merges CP15 flush triggers, stalls the core, waits for the
// cache to go idle, then walks every line issuing invalidates over valid/ready.
module a23_cache_flush_seq #(
    parameter  int LINES  = 256,
    localparam int LINE_W = $clog2(LINES)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_flush_req,
    input  logic              i_cache_enable,
    input  logic [31:0]       i_disruptive_area,
    input  logic              i_access_valid,
    input  logic [31:0]       i_access_address,
    input  logic              i_cache_idle,
    input  logic              i_inv_ready,
    output logic              o_inv_valid,
    output logic [LINE_W-1:0] o_inv_index,
    output logic              o_stall,
    output logic              o_flush_busy,
    output logic              o_flush_done,
    output logic [15:0]       o_flush_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRAIN = 2'd1;
    localparam logic [1:0] WALK  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [LINE_W-1:0] LAST = LINE_W'(LINES - 1);

    logic [1:0]        state;
    logic              pending;
    logic [LINE_W-1:0] index;
    logic              enable_q;
    logic [15:0]       count;

    logic enable_fall;
    logic area_hit;
    logic trigger;
    logic unused_addr;

    assign enable_fall = enable_q & ~i_cache_enable;
    // Only the low 64MB is split into 2MB disruptive regions.
    assign area_hit    = i_access_valid & i_cache_enable &
                         (i_access_address[31:26] == 6'd0) &
                         i_disruptive_area[i_access_address[25:21]];
    assign trigger     = i_flush_req | enable_fall | area_hit;
    assign unused_addr = ^i_access_address[20:0];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            pending  <= 1'b0;
            index    <= '0;
            enable_q <= 1'b0;
            count    <= 16'd0;
        end else begin
            enable_q <= i_cache_enable;
            case (state)
                IDLE: if (trigger) state <= DRAIN;
                // Triggers here are absorbed: the walk has not started yet.
                DRAIN: if (i_cache_idle) begin
                    state <= WALK;
                    index <= '0;
                end
                WALK: begin
                    if (trigger) pending <= 1'b1;
                    if (i_inv_ready) begin
                        if (index == LAST) state <= DONE;
                        else               index <= index + 1'b1;
                    end
                end
                DONE: begin
                    if (count != 16'hFFFF) count <= count + 16'd1;
                    pending <= 1'b0;
                    state   <= (pending | trigger) ? DRAIN : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_inv_valid   = (state == WALK);
    assign o_inv_index   = index;
    assign o_stall       = (state != IDLE);
    assign o_flush_busy  = o_stall;
    assign o_flush_done  = (state == DONE);
    assign o_flush_count = count;

endmodule

// File: tb/tb_a23_cache_flush_seq.sv
// Directed bench for a23_cache_flush_seq with LINES=8; inputs change 1ns after
// the rising edge and outputs are checked at the same point.
module tb_a23_cache_flush_seq;

    localparam int LINES = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_req;
    logic        cache_enable;
    logic [31:0] disruptive_area;
    logic        access_valid;
    logic [31:0] access_address;
    logic        cache_idle;
    logic        inv_ready;
    logic        inv_valid;
    logic [2:0]  inv_index;
    logic        stall;
    logic        flush_busy;
    logic        flush_done;
    logic [15:0] flush_count;

    int total = 0;
    int bad   = 0;

    a23_cache_flush_seq #(.LINES(LINES)) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_flush_req       (flush_req),
        .i_cache_enable    (cache_enable),
        .i_disruptive_area (disruptive_area),
        .i_access_valid    (access_valid),
        .i_access_address  (access_address),
        .i_cache_idle      (cache_idle),
        .i_inv_ready       (inv_ready),
        .o_inv_valid       (inv_valid),
        .o_inv_index       (inv_index),
        .o_stall           (stall),
        .o_flush_busy      (flush_busy),
        .o_flush_done      (flush_done),
        .o_flush_count     (flush_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts remaining stalled cycles, bounded so a stuck flush still terminates.
    task automatic run_to_idle(output int n);
        n = 0;
        while (stall && n < 200) begin
            n++;
            tick();
        end
    endtask

    task automatic pulse_req();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (stall !== 1'b0 || flush_busy !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b/%b exp=0/0", stall, flush_busy); end
        total++; if (inv_valid !== 1'b0 || inv_index !== 3'd0) begin bad++; $display("FAIL reset_inv got=%b/%0d exp=0/0", inv_valid, inv_index); end
        total++; if (flush_done !== 1'b0 || flush_count !== 16'd0) begin bad++; $display("FAIL reset_done got=%b/%0d exp=0/0", flush_done, flush_count); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        pulse_req();
        total++; if (stall !== 1'b1 || flush_busy !== 1'b1 || inv_valid !== 1'b0) begin bad++; $display("FAIL basic_drain got=%b%b%b exp=110", stall, flush_busy, inv_valid); end
        for (int i = 0; i < LINES; i++) begin
            tick();
            total++; if (inv_valid !== 1'b1 || inv_index !== 3'(i) || stall !== 1'b1) begin bad++; $display("FAIL basic_walk got=%b/%0d exp=1/%0d", inv_valid, inv_index, i); end
        end
        tick();
        total++; if (flush_done !== 1'b1 || inv_valid !== 1'b0 || stall !== 1'b1 || flush_count !== 16'd0) begin bad++; $display("FAIL basic_done got=%b%b%b cnt=%0d exp=101 cnt=0", flush_done, inv_valid, stall, flush_count); end
        tick();
        total++; if (stall !== 1'b0 || flush_done !== 1'b0 || flush_count !== 16'd1) begin bad++; $display("FAIL basic_idle got=%b%b cnt=%0d exp=00 cnt=1", stall, flush_done, flush_count); end
    endtask

    task automatic test_drain();
        int n;
        cache_idle = 1'b0;
        pulse_req();
        for (int k = 0; k < 5; k++) begin
            total++; if (inv_valid !== 1'b0 || stall !== 1'b1) begin bad++; $display("FAIL drain_wait got=%b/%b exp=0/1", inv_valid, stall); end
            tick();
        end
        total++; if (inv_valid !== 1'b0) begin bad++; $display("FAIL drain_n6 got=%b exp=0", inv_valid); end
        cache_idle = 1'b1;
        tick();
        total++; if (inv_valid !== 1'b1 || inv_index !== 3'd0) begin bad++; $display("FAIL drain_walk_start got=%b/%0d exp=1/0", inv_valid, inv_index); end
        run_to_idle(n);
        total++; if (n !== 9 || flush_count !== 16'd2) begin bad++; $display("FAIL drain_len got=%0d cnt=%0d exp=9 cnt=2", n, flush_count); end
    endtask

    // Ready starts low on the first walk cycle, so each of the 8 lines costs 2 cycles.
    task automatic test_ready_toggle();
        int  acc = 0;
        int  low = 0;
        int  sc  = 0;
        logic ph = 1'b0;
        pulse_req();
        for (int k = 0; k < 100 && stall; k++) begin
            sc++;
            if (inv_valid) begin
                total++; if (inv_index !== 3'(acc)) begin bad++; $display("FAIL toggle_index got=%0d exp=%0d", inv_index, acc); end
                inv_ready = ph;
                if (ph) acc++;
                else    low++;
                ph = ~ph;
            end else begin
                inv_ready = 1'b1;
            end
            tick();
        end
        inv_ready = 1'b1;
        total++; if (acc !== 8 || low !== 8) begin bad++; $display("FAIL toggle_accepts got=%0d/%0d exp=8/8", acc, low); end
        total++; if (sc !== 18 || flush_count !== 16'd3) begin bad++; $display("FAIL toggle_stall got=%0d cnt=%0d exp=18 cnt=3", sc, flush_count); end
    endtask

    task automatic test_disruptive();
        int n;
        disruptive_area = 32'h0000_0004;
        cache_enable    = 1'b1;
        tick();
        tick();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL dis_enable_rise got=%b exp=0", stall); end
        access_valid   = 1'b1;
        access_address = 32'h0040_0000;
        tick();
        access_valid = 1'b0;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL dis_hit got=%b exp=1", stall); end
        run_to_idle(n);
        total++; if (n !== 10 || flush_count !== 16'd4) begin bad++; $display("FAIL dis_hit_len got=%0d cnt=%0d exp=10 cnt=4", n, flush_count); end
        access_valid   = 1'b1;
        access_address = 32'h0440_0000;
        tick();
        access_valid = 1'b0;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL dis_high_addr got=%b exp=0", stall); end
        cache_enable = 1'b0;
        tick();
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL dis_enable_fall got=%b exp=1", stall); end
        run_to_idle(n);
        total++; if (n !== 10 || flush_count !== 16'd5) begin bad++; $display("FAIL dis_fall_len got=%0d cnt=%0d exp=10 cnt=5", n, flush_count); end
        access_valid   = 1'b1;
        access_address = 32'h0040_0000;
        tick();
        access_valid = 1'b0;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL dis_disabled got=%b exp=0", stall); end
    endtask

    task automatic test_back_to_back();
        int n;
        int k = 0;
        pulse_req();
        while (!flush_done && k < 50) begin k++; tick(); end
        total++; if (flush_done !== 1'b1) begin bad++; $display("FAIL b2b_done_seen got=%b exp=1", flush_done); end
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        total++; if (stall !== 1'b1 || inv_valid !== 1'b0 || flush_done !== 1'b0) begin bad++; $display("FAIL b2b_redrain got=%b%b%b exp=100", stall, inv_valid, flush_done); end
        tick();
        total++; if (inv_valid !== 1'b1 || inv_index !== 3'd0) begin bad++; $display("FAIL b2b_rewalk got=%b/%0d exp=1/0", inv_valid, inv_index); end
        run_to_idle(n);
        total++; if (n !== 9 || flush_count !== 16'd7) begin bad++; $display("FAIL b2b_len got=%0d cnt=%0d exp=9 cnt=7", n, flush_count); end
    endtask

    // Requests at walk index 3, 5 and 6 collapse into one extra flush; requests
    // during either DRAIN are absorbed.
    task automatic test_pending();
        int   dones = 0;
        int   sc    = 0;
        logic after_first = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pulse_req();
        for (int k = 0; k < 80 && stall; k++) begin
            sc++;
            if (after_first) begin
                total++; if (inv_valid !== 1'b0 || flush_done !== 1'b0) begin bad++; $display("FAIL pend_direct_drain got=%b%b exp=00", inv_valid, flush_done); end
                after_first = 1'b0;
            end
            if (flush_done) begin
                dones++;
                after_first = (dones == 1);
            end
            flush_req = (dones == 0 && inv_valid && (inv_index == 3'd3 || inv_index == 3'd5 || inv_index == 3'd6))
                      || (!inv_valid && !flush_done);
            tick();
        end
        flush_req = 1'b0;
        total++; if (dones !== 2 || sc !== 20) begin bad++; $display("FAIL pend_flushes got=%0d/%0d exp=2/20", dones, sc); end
        total++; if (flush_count !== 16'd2 || stall !== 1'b0) begin bad++; $display("FAIL pend_count got=%0d/%b exp=2/0", flush_count, stall); end
    endtask

    task automatic test_reset_mid();
        int n;
        int k = 0;
        pulse_req();
        while (!(inv_valid && inv_index == 3'd4) && k < 20) begin k++; tick(); end
        total++; if (inv_valid !== 1'b1 || inv_index !== 3'd4) begin bad++; $display("FAIL rmid_reach got=%b/%0d exp=1/4", inv_valid, inv_index); end
        rst = 1'b1;
        flush_req = 1'b1;
        tick();
        rst = 1'b0;
        flush_req = 1'b0;
        total++; if (stall !== 1'b0 || inv_valid !== 1'b0 || flush_count !== 16'd0 || inv_index !== 3'd0) begin bad++; $display("FAIL rmid_cleared got=%b%b cnt=%0d idx=%0d exp=00 cnt=0 idx=0", stall, inv_valid, flush_count, inv_index); end
        tick();
        total++; if (stall !== 1'b0 || inv_valid !== 1'b0) begin bad++; $display("FAIL rmid_quiet got=%b%b exp=00", stall, inv_valid); end
        pulse_req();
        tick();
        total++; if (inv_valid !== 1'b1 || inv_index !== 3'd0) begin bad++; $display("FAIL rmid_restart got=%b/%0d exp=1/0", inv_valid, inv_index); end
        run_to_idle(n);
        total++; if (n !== 9 || flush_count !== 16'd1) begin bad++; $display("FAIL rmid_len got=%0d cnt=%0d exp=9 cnt=1", n, flush_count); end
    endtask

    initial begin
        rst             = 1'b1;
        flush_req       = 1'b0;
        cache_enable    = 1'b0;
        disruptive_area = 32'd0;
        access_valid    = 1'b0;
        access_address  = 32'd0;
        cache_idle      = 1'b1;
        inv_ready       = 1'b1;
        test_reset();
        test_basic();
        test_drain();
        test_ready_toggle();
        test_disruptive();
        test_back_to_back();
        test_pending();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
